// File: rtl/id_ex_hazard_stage.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_stage
//   ID/EX pipeline register with a single valid/ready slot. Detects load-use
//   hazards against the instruction held in the slot, bypasses the write-back
//   result into the captured operands, refreshes held operands from write-back
//   while the slot is stalled, supports a synchronous flush and keeps a
//   saturating count of cycles where upstream was stalled.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_flush                    synchronous flush (highest priority)
//   i_valid / o_ready          upstream handshake (o_ready is combinational)
//   i_pc .. i_imm              decoded instruction fields and operand data
//   i_wb_wr/i_wb_rd/i_wb_data  write-back port, used for bypass and refresh
//   i_cnt_clr                  synchronous clear of the stall counter
//   o_valid / i_ready          downstream handshake
//   o_pc .. o_ctrl             registered slot contents
//   o_stall_cnt                saturating stall-cycle counter
// ---------------------------------------------------------------------------
module id_ex_hazard_stage #(
  parameter int XLEN     = 32,
  parameter int REG_ADDR = 5,
  parameter int CTRL_W   = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [XLEN-1:0]     i_pc,
  input  logic [REG_ADDR-1:0] i_rs1_addr,
  input  logic [REG_ADDR-1:0] i_rs2_addr,
  input  logic                i_rs1_used,
  input  logic                i_rs2_used,
  input  logic [REG_ADDR-1:0] i_rd_addr,
  input  logic                i_reg_wr,
  input  logic                i_mem_rd,
  input  logic [CTRL_W-1:0]   i_ctrl,
  input  logic [XLEN-1:0]     i_rs1_data,
  input  logic [XLEN-1:0]     i_rs2_data,
  input  logic [XLEN-1:0]     i_imm,
  input  logic                i_wb_wr,
  input  logic [REG_ADDR-1:0] i_wb_rd,
  input  logic [XLEN-1:0]     i_wb_data,
  input  logic                i_cnt_clr,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [XLEN-1:0]     o_pc,
  output logic [XLEN-1:0]     o_rs1_data,
  output logic [XLEN-1:0]     o_rs2_data,
  output logic [XLEN-1:0]     o_imm,
  output logic [REG_ADDR-1:0] o_rs1_addr,
  output logic [REG_ADDR-1:0] o_rs2_addr,
  output logic [REG_ADDR-1:0] o_rd_addr,
  output logic                o_reg_wr,
  output logic                o_mem_rd,
  output logic [CTRL_W-1:0]   o_ctrl,
  output logic [CNT_W-1:0]    o_stall_cnt
);

  // Slot registers; outputs are direct copies.
  logic                r_valid;
  logic [XLEN-1:0]     r_pc;
  logic [XLEN-1:0]     r_rs1_data;
  logic [XLEN-1:0]     r_rs2_data;
  logic [XLEN-1:0]     r_imm;
  logic [REG_ADDR-1:0] r_rs1_addr;
  logic [REG_ADDR-1:0] r_rs2_addr;
  logic [REG_ADDR-1:0] r_rd_addr;
  logic                r_reg_wr;
  logic                r_mem_rd;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic                w_hazard;
  logic                w_ready;
  logic                w_accept;
  logic                w_wb_live;
  logic [XLEN-1:0]     w_rs1_cap;
  logic [XLEN-1:0]     w_rs2_cap;
  logic                w_rs1_refresh;
  logic                w_rs2_refresh;
  logic                w_stall;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Write-back to x0 is architecturally discarded, so it never bypasses.
  assign w_wb_live = i_wb_wr && (i_wb_rd != '0);

  // Load in the slot whose result a source of the incoming instruction needs.
  assign w_hazard = r_valid && r_mem_rd && (r_rd_addr != '0) &&
                    ((i_rs1_used && (i_rs1_addr == r_rd_addr)) ||
                     (i_rs2_used && (i_rs2_addr == r_rd_addr)));

  assign w_ready  = !i_flush && !w_hazard && (!r_valid || i_ready);
  assign w_accept = i_valid && w_ready;
  assign w_stall  = i_valid && !w_ready && !i_flush;

  // Refresh is only meaningful while the slot is held; the sequential block
  // applies it only on that branch.
  assign w_rs1_refresh = w_wb_live && (i_wb_rd == r_rs1_addr);
  assign w_rs2_refresh = w_wb_live && (i_wb_rd == r_rs2_addr);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_rs1_cap = i_rs1_data;
    w_rs2_cap = i_rs2_data;
    if (w_wb_live && (i_wb_rd == i_rs1_addr)) w_rs1_cap = i_wb_data;
    if (w_wb_live && (i_wb_rd == i_rs2_addr)) w_rs2_cap = i_wb_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_reg_wr   <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_ctrl     <= '0;
    end else if (i_flush) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_reg_wr   <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_ctrl     <= '0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_pc       <= i_pc;
      r_rs1_data <= w_rs1_cap;
      r_rs2_data <= w_rs2_cap;
      r_imm      <= i_imm;
      r_rs1_addr <= i_rs1_addr;
      r_rs2_addr <= i_rs2_addr;
      r_rd_addr  <= i_rd_addr;
      r_reg_wr   <= i_reg_wr;
      r_mem_rd   <= i_mem_rd;
      r_ctrl     <= i_ctrl;
    end else if (r_valid && i_ready) begin
      // Slot drained with nothing new: emit a bubble, fields are don't-care.
      r_valid <= 1'b0;
    end else if (r_valid) begin
      // Held slot: keep operands current with results retiring meanwhile.
      if (w_rs1_refresh) r_rs1_data <= i_wb_data;
      if (w_rs2_refresh) r_rs2_data <= i_wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_ready     = w_ready;
  assign o_valid     = r_valid;
  assign o_pc        = r_pc;
  assign o_rs1_data  = r_rs1_data;
  assign o_rs2_data  = r_rs2_data;
  assign o_imm       = r_imm;
  assign o_rs1_addr  = r_rs1_addr;
  assign o_rs2_addr  = r_rs2_addr;
  assign o_rd_addr   = r_rd_addr;
  assign o_reg_wr    = r_reg_wr;
  assign o_mem_rd    = r_mem_rd;
  assign o_ctrl      = r_ctrl;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_hazard_stage
//   Directed bench for id_ex_hazard_stage. Inputs change 1 ns after a rising
//   edge; o_ready is sampled 1 ns later and registered outputs 1 ns after the
//   following edge. The stall counter is 2 bits wide so saturation is short.
// ---------------------------------------------------------------------------
module tb_id_ex_hazard_stage;

  localparam int XLEN     = 32;
  localparam int REG_ADDR = 5;
  localparam int CTRL_W   = 16;
  localparam int CNT_W    = 2;

  logic                clk;
  logic                rst_n;
  logic                i_flush;
  logic                i_valid;
  logic                o_ready;
  logic [XLEN-1:0]     i_pc;
  logic [REG_ADDR-1:0] i_rs1_addr;
  logic [REG_ADDR-1:0] i_rs2_addr;
  logic                i_rs1_used;
  logic                i_rs2_used;
  logic [REG_ADDR-1:0] i_rd_addr;
  logic                i_reg_wr;
  logic                i_mem_rd;
  logic [CTRL_W-1:0]   i_ctrl;
  logic [XLEN-1:0]     i_rs1_data;
  logic [XLEN-1:0]     i_rs2_data;
  logic [XLEN-1:0]     i_imm;
  logic                i_wb_wr;
  logic [REG_ADDR-1:0] i_wb_rd;
  logic [XLEN-1:0]     i_wb_data;
  logic                i_cnt_clr;
  logic                o_valid;
  logic                i_ready;
  logic [XLEN-1:0]     o_pc;
  logic [XLEN-1:0]     o_rs1_data;
  logic [XLEN-1:0]     o_rs2_data;
  logic [XLEN-1:0]     o_imm;
  logic [REG_ADDR-1:0] o_rs1_addr;
  logic [REG_ADDR-1:0] o_rs2_addr;
  logic [REG_ADDR-1:0] o_rd_addr;
  logic                o_reg_wr;
  logic                o_mem_rd;
  logic [CTRL_W-1:0]   o_ctrl;
  logic [CNT_W-1:0]    o_stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  id_ex_hazard_stage #(
    .XLEN(XLEN), .REG_ADDR(REG_ADDR), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_pc(i_pc), .i_rs1_addr(i_rs1_addr),
    .i_rs2_addr(i_rs2_addr), .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
    .i_rd_addr(i_rd_addr), .i_reg_wr(i_reg_wr), .i_mem_rd(i_mem_rd),
    .i_ctrl(i_ctrl), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_imm(i_imm), .i_wb_wr(i_wb_wr), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .i_cnt_clr(i_cnt_clr), .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_imm(o_imm),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr),
    .o_reg_wr(o_reg_wr), .o_mem_rd(o_mem_rd), .o_ctrl(o_ctrl),
    .o_stall_cnt(o_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction; sources with address 0 are treated as unused.
  task automatic drive(input logic [XLEN-1:0] pc, input logic [REG_ADDR-1:0] rs1,
                       input logic [REG_ADDR-1:0] rs2, input logic [REG_ADDR-1:0] rd,
                       input logic mem_rd, input logic [XLEN-1:0] d1,
                       input logic [XLEN-1:0] d2, input logic [XLEN-1:0] imm);
    i_valid    = 1'b1;
    i_pc       = pc;
    i_rs1_addr = rs1;
    i_rs2_addr = rs2;
    i_rs1_used = (rs1 != '0);
    i_rs2_used = (rs2 != '0);
    i_rd_addr  = rd;
    i_reg_wr   = 1'b1;
    i_mem_rd   = mem_rd;
    i_ctrl     = pc[15:0] ^ 16'h5A5A;
    i_rs1_data = d1;
    i_rs2_data = d2;
    i_imm      = imm;
  endtask

  task automatic wb(input logic en, input logic [REG_ADDR-1:0] rd,
                    input logic [XLEN-1:0] data);
    i_wb_wr   = en;
    i_wb_rd   = rd;
    i_wb_data = data;
  endtask

  initial begin
    rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_pc = '0; i_rs1_addr = '0; i_rs2_addr = '0; i_rs1_used = 1'b0;
    i_rs2_used = 1'b0; i_rd_addr = '0; i_reg_wr = 1'b0; i_mem_rd = 1'b0;
    i_ctrl = '0; i_rs1_data = '0; i_rs2_data = '0; i_imm = '0;
    i_wb_wr = 1'b0; i_wb_rd = '0; i_wb_data = '0; i_cnt_clr = 1'b0;

    // Reset state
    tick();
    check("rst_valid", o_valid, 0);
    check("rst_pc", o_pc, 0);
    check("rst_ctrl", o_ctrl, 0);
    check("rst_cnt", o_stall_cnt, 0);
    rst_n = 1'b1;

    // 1: back-to-back stream
    tick();
    drive(32'h0, 5'd2, 5'd3, 5'd1, 1'b0, 32'h1, 32'h2, 32'h0);
    #1 check("s1_ready0", o_ready, 1);
    tick();
    check("s1_valid0", o_valid, 1);
    check("s1_pc0", o_pc, 32'h0);
    drive(32'h4, 5'd1, 5'd3, 5'd2, 1'b0, 32'h3, 32'h4, 32'h8);
    #1 check("s1_ready1", o_ready, 1);
    tick();
    check("s1_valid1", o_valid, 1);
    check("s1_pc1", o_pc, 32'h4);
    check("s1_ctrl1", o_ctrl, 32'h4 ^ 32'h5A5A);
    i_valid = 1'b0;
    tick();
    check("s1_drain", o_valid, 0);

    // 2: load-use, exactly one bubble
    drive(32'h8, 5'd1, 5'd0, 5'd5, 1'b1, 32'h0, 32'h0, 32'h10);
    tick();
    check("s2_ld_memrd", o_mem_rd, 1);
    check("s2_ld_rd", o_rd_addr, 5);
    drive(32'hC, 5'd5, 5'd1, 5'd6, 1'b0, 32'h0, 32'h0, 32'h0);
    #1 check("s2_ready_haz", o_ready, 0);
    tick();
    check("s2_bubble", o_valid, 0);
    check("s2_cnt", o_stall_cnt, 1);
    #1 check("s2_ready_after", o_ready, 1);
    tick();
    check("s2_use_valid", o_valid, 1);
    check("s2_use_pc", o_pc, 32'hC);
    // load to x0 never hazards
    drive(32'h10, 5'd1, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0);
    tick();
    drive(32'h14, 5'd0, 5'd0, 5'd7, 1'b0, 32'h0, 32'h0, 32'h0);
    i_rs1_used = 1'b1;
    #1 check("s2_x0_ready", o_ready, 1);
    tick();
    check("s2_x0_pc", o_pc, 32'h14);

    // 3: write-back bypass at capture
    drive(32'h20, 5'd3, 5'd4, 5'd8, 1'b0, 32'h11, 32'h22, 32'h0);
    wb(1'b1, 5'd3, 32'hAA);
    tick();
    check("s3_byp_rs1", o_rs1_data, 32'hAA);
    check("s3_byp_rs2", o_rs2_data, 32'h22);
    drive(32'h24, 5'd0, 5'd4, 5'd8, 1'b0, 32'h11, 32'h22, 32'h0);
    wb(1'b1, 5'd0, 32'hAA);
    tick();
    check("s3_x0_rs1", o_rs1_data, 32'h11);
    wb(1'b0, 5'd0, 32'h0);

    // 4: held-operand refresh
    drive(32'h40, 5'd2, 5'd7, 5'd9, 1'b0, 32'h33, 32'h55, 32'h99);
    tick();
    check("s4_cap_rs2", o_rs2_data, 32'h55);
    i_valid = 1'b0;
    i_ready = 1'b0;
    tick();
    check("s4_c1_rs2", o_rs2_data, 32'h55);
    wb(1'b1, 5'd7, 32'h1234);
    tick();
    check("s4_c2_rs2", o_rs2_data, 32'h1234);
    check("s4_c2_rs1", o_rs1_data, 32'h33);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    check("s4_c3_rs2", o_rs2_data, 32'h1234);
    check("s4_c3_pc", o_pc, 32'h40);
    check("s4_c3_imm", o_imm, 32'h99);
    check("s4_c3_valid", o_valid, 1);
    i_ready = 1'b1;
    tick();
    check("s4_drain", o_valid, 0);

    // 5: flush beats accept
    drive(32'h80, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    check("s5_valid", o_valid, 1);
    drive(32'h84, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 32'h0, 32'h0);
    i_flush = 1'b1;
    #1 check("s5_ready", o_ready, 0);
    tick();
    check("s5_flush_valid", o_valid, 0);
    check("s5_flush_pc", o_pc, 0);
    check("s5_cnt_hold", o_stall_cnt, 1);
    i_flush = 1'b0;
    i_valid = 1'b0;

    // 6: saturating counter, clear wins
    i_cnt_clr = 1'b1;
    tick();
    check("s6_clr0", o_stall_cnt, 0);
    i_cnt_clr = 1'b0;
    drive(32'h100, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    check("s6_acc_cnt", o_stall_cnt, 0);
    i_ready = 1'b0;
    drive(32'h104, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, 32'h0, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("s6_sat%0d", k), o_stall_cnt, (k < 3) ? k : 3);
    end
    check("s6_hold_pc", o_pc, 32'h100);
    i_cnt_clr = 1'b1;
    tick();
    check("s6_clr_wins", o_stall_cnt, 0);
    i_cnt_clr = 1'b0;

    // Reset asserted while a slot is held
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", o_valid, 0);
    check("rst_mid_pc", o_pc, 0);
    i_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_mid_after", o_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
